// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg: shared types and default sizing for the round-robin arbiter.
// Holds the IDLE/BUSY state enum and the N / MAX_HOLD defaults.
package rr_arbiter_pkg;

  localparam int N_DEF        = 8;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotated priority encoder; first set req bit scanning up from last+1.
// Ports: req[N] in, last[W] in, winner[W] out, found out (any req set).
module rr_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         found
);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin arbiter driving an N:1 mux select.
// Ports: clk, rst_n (sync, active-low), req[N] in; gnt[N], sel[W], gnt_valid out.
// Optional hold timeout compiled in with macro RR_ARBITER_TIMEOUT_EN.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] sel,
  output logic         gnt_valid
);

  if (N < 2 || MAX_HOLD < 2) begin : g_bad_cfg
    $error("rr_arbiter: N and MAX_HOLD must be >= 2");
  end

  state_t         state, state_d;
  logic [N-1:0]   gnt_d;
  logic [W-1:0]   sel_d;
  logic [W-1:0]   last, last_d;
  logic [N-1:0]   hold_mask;
  logic [N-1:0]   others;
  logic [N-1:0]   pick_req;
  logic [W-1:0]   pick_last;
  logic [W-1:0]   win;
  logic           found;
  logic           hit;
  logic           rel;
  logic           grab;

  // In BUSY the holder is excluded and the scan starts just past it,
  // so a holder released this cycle ranks behind every other requester.
  assign hold_mask = N'(1) << sel;
  assign others    = req & ~hold_mask;
  assign pick_req  = (state == BUSY) ? others : req;
  assign pick_last = (state == BUSY) ? sel : last;

  rr_pick #(.N(N), .W(W)) u_pick (
    .req    (pick_req),
    .last   (pick_last),
    .winner (win),
    .found  (found)
  );

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt, cnt_d;

  assign hit = (cnt == CNT_MAX) && (|others);

  // Saturates at CNT_MAX while no one else is waiting.
  always_comb begin
    cnt_d = cnt;
    if (grab)
      cnt_d = '0;
    else if (state == BUSY && cnt != CNT_MAX)
      cnt_d = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt_d;
  end
`else
  assign hit = 1'b0;
`endif

  assign rel = !req[sel] || hit;

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    sel_d   = sel;
    last_d  = last;
    grab    = 1'b0;
    unique case (state)
      IDLE: grab = found;
      BUSY: begin
        if (rel) begin
          last_d = sel;
          grab   = found;
          if (!found) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: ;
    endcase
    if (grab) begin
      state_d = BUSY;
      gnt_d   = N'(1) << win;
      sel_d   = win;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      last  <= W'(N - 1);
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      sel   <= sel_d;
      last  <= last_d;
    end
  end

  assign gnt_valid = (state == BUSY);

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed + random check of rr_arbiter (N=8, MAX_HOLD=4)
// against a behavioural round-robin model.
module tb_rr_arbiter;

  localparam int N  = 8;
  localparam int MH = 4;
`ifdef RR_ARBITER_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [2:0]   sel;
  logic         gnt_valid;

  int n_chk  = 0;
  int n_fail = 0;

  rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  // Behavioural model
  bit m_ok   = 1'b0;
  bit m_busy = 1'b0;
  int m_hold = 0;
  int m_last = N - 1;
  int m_cnt  = 0;

  function automatic int scan(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] oth;
    int w;
    if (!rst_n) begin
      m_ok = 1'b1; m_busy = 1'b0; m_hold = 0; m_last = N - 1; m_cnt = 0;
    end else if (!m_busy) begin
      w = scan(req, m_last + 1);
      if (w >= 0) begin m_busy = 1'b1; m_hold = w; m_cnt = 0; end
    end else begin
      oth = req;
      oth[m_hold] = 1'b0;
      if (!req[m_hold] || (TMO && m_cnt == MH - 1 && oth != 0)) begin
        m_last = m_hold;
        w = scan(oth, m_last + 1);
        if (w >= 0) begin m_hold = w; m_cnt = 0; end
        else m_busy = 1'b0;
      end else if (m_cnt < MH - 1) begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    if (m_ok) begin
      eg = m_busy ? (N'(1) << m_hold) : '0;
      n_chk++;
      if (gnt !== eg || sel !== 3'(m_hold) || gnt_valid !== m_busy) begin
        n_fail++;
        $display("FAIL model t=%0t gnt=%h sel=%0d v=%b exp gnt=%h sel=%0d v=%b",
                 $time, gnt, sel, gnt_valid, eg, m_hold, m_busy);
      end
      n_chk++;
      if ($countones(gnt) > 1 || (gnt_valid && !gnt[sel])) begin
        n_fail++;
        $display("FAIL onehot gnt=%h sel=%0d v=%b", gnt, sel, gnt_valid);
      end
    end
  end

  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [N-1:0] g,
                     input int s, input logic v);
    n_chk++;
    if (gnt !== g || sel !== 3'(s) || gnt_valid !== v) begin
      n_fail++;
      $display("FAIL %s got gnt=%h sel=%0d v=%b exp gnt=%h sel=%0d v=%b",
               nm, gnt, sel, gnt_valid, g, s, v);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step('0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    int e;
    @(posedge clk); #1;
    do_reset();
    chk("reset", 8'h00, 0, 1'b0);

    step(8'h04); chk("single", 8'h04, 2, 1'b1);
    step(8'h04); chk("single_hold1", 8'h04, 2, 1'b1);
    step(8'h04); chk("single_hold2", 8'h04, 2, 1'b1);
    step(8'h00); chk("release2", 8'h00, 2, 1'b0);

    step(8'h08); chk("grant3", 8'h08, 3, 1'b1);
    step(8'h00); chk("idle_sel3", 8'h00, 3, 1'b0);

    step(8'h40); chk("grant6", 8'h40, 6, 1'b1);
    step(8'h00); chk("idle_sel6", 8'h00, 6, 1'b0);
    step(8'h41); chk("wrap", 8'h01, 0, 1'b1);
    step(8'h00);

    do_reset();
    step(8'hFF); chk("rot0", 8'h01, 0, 1'b1);
    for (int i = 1; i <= N; i++) begin
      r = 8'hFF;
      r[(i - 1) % N] = 1'b0;
      step(r);
      chk($sformatf("rot%0d", i), N'(1) << (i % N), i % N, 1'b1);
    end

    do_reset();
    step(8'h20); chk("hold5", 8'h20, 5, 1'b1);
    rst_n = 1'b0;
    step(8'hFF); chk("mid_reset", 8'h00, 0, 1'b0);
    rst_n = 1'b1;
    step(8'hFF); chk("post_reset", 8'h01, 0, 1'b1);

    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(8'h03);
      e = TMO ? ((k / MH) % 2) : 0;
      chk($sformatf("timeout%0d", k), N'(1) << e, e, 1'b1);
    end

    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      if ($urandom_range(0, 9) == 0) r = N'($urandom);
      else if ($urandom_range(0, 2) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
      if (gnt_valid && $urandom_range(0, 3) == 0) r[sel] = 1'b0;
      step(r);
    end
    rst_n = 1'b1;
    step('0);
    step('0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
